nes_pad_reader: RTL

Serial reader for the NES-style game controller. It drives the pad's latch and clock lines and shifts in the 8 button states over the pad's serial data line. It presents them as the active-high `controller[7:0]` byte that the memory-stage button decode consumes. It polls autonomously at a fixed rate, and the published byte only changes atomically at the end of a complete scan.

---
 rtl/nes_pad_pkg.sv | 32 +++
 rtl/sync2.sv | 31 +++
 rtl/nes_pad_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nes_pad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nes_pad_pkg : scan state encoding and controller button bit positions
// Revision    : 1.0
// ---------------------------------------------------------------------------
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_SHIFT_LO = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int unsigned NUM_BTN    = 8;
  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

  function automatic logic is_scanning(input state_e s);
    return (s == ST_LATCH) || (s == ST_WAIT) || (s == ST_SHIFT_HI) || (s == ST_SHIFT_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync2    : two-flop synchronizer with configurable reset value
// Revision : 1.0
// ---------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nes_pad_reader : polls an NES pad and publishes the button byte atomically
// Revision       : 1.0
// ---------------------------------------------------------------------------
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int unsigned HALF        = 300,
  parameter int unsigned POLL_PERIOD = 833_333
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               poll_req,
  input  logic               pad_data,
  output logic               pad_latch,
  output logic               pad_clk,
  output logic [NUM_BTN-1:0] controller,
  output logic               valid,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(2 * HALF);
  localparam int unsigned TMR_W = $clog2(POLL_PERIOD);

  localparam logic [CNT_W-1:0] LATCH_LAST  = CNT_W'(2 * HALF - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(HALF - 1);
  localparam logic [TMR_W-1:0] POLL_RELOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [2:0]       LAST_PAIR   = 3'(NUM_BTN - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pend_q, pend_d;
  logic [NUM_BTN-2:0] shift_q, shift_d;
  logic [NUM_BTN-1:0] ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic               latch_q, latch_d;
  logic               pclk_q, pclk_d;
  logic               busy_q, busy_d;

  logic w_pad_sync;
  logic w_pressed;
  logic w_start_req;
  logic w_cnt_zero;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .d_i       (pad_data),
    .q_o       (w_pad_sync)
  );

  assign w_pressed   = ~w_pad_sync;
  assign w_start_req = poll_req | pend_q | (timer_q == '0);
  assign w_cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    timer_d = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
    pend_d  = pend_q | (poll_req & is_scanning(state_q));
    shift_d = shift_q;
    ctrl_d  = ctrl_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE may chain straight into a pending scan without an IDLE cycle
        if (w_start_req) begin
          state_d = ST_LATCH;
          cnt_d   = LATCH_LAST;
          timer_d = POLL_RELOAD;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (w_cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = HALF_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) begin
          shift_d = {shift_q[NUM_BTN-3:0], w_pressed};
          state_d = ST_SHIFT_HI;
          cnt_d   = HALF_LAST;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (w_cnt_zero) begin
          state_d = ST_SHIFT_LO;
          cnt_d   = HALF_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SHIFT_LO: begin
        if (w_cnt_zero) begin
          if (bit_q == LAST_PAIR) begin
            ctrl_d  = {shift_q, w_pressed};
            state_d = ST_DONE;
          end else begin
            shift_d = {shift_q[NUM_BTN-3:0], w_pressed};
            bit_d   = bit_q + 3'd1;
            state_d = ST_SHIFT_HI;
            cnt_d   = HALF_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pad-facing strobes are registered from the next state so they never glitch
    latch_d = (state_d == ST_LATCH);
    pclk_d  = (state_d == ST_SHIFT_HI);
    busy_d  = is_scanning(state_d);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      pend_q  <= 1'b0;
      shift_q <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      shift_q <= shift_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      busy_q  <= busy_d;
    end
  end

  assign pad_latch  = latch_q;
  assign pad_clk    = pclk_q;
  assign controller = ctrl_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
